// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_byte_tx_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;

    modport master (output data_in, output valid, input  ready);
    modport slave  (input  data_in, input  valid, output ready);
endinterface

// File: rtl/tt_um_uart_byte_tx.sv
// Tiny Tapeout wrapper: sends ui_in + uio_in continuously on uo_out[0].
module tt_um_uart_byte_tx (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    logic [1:0] rst_sync_q;
    logic       rst;
    logic       tx;
    logic       busy;
    logic       unused_ena;

    uart_byte_tx_if bus ();

    // Two-flop synchroniser on the external reset, inverted to active-high.
    always_ff @(posedge clk) begin
        rst_sync_q <= {rst_sync_q[0], !rst_n};
    end

    assign rst         = rst_sync_q[1];
    assign bus.data_in = ui_in + uio_in;
    assign bus.valid   = 1'b1;
    assign unused_ena  = ena;

    uart_byte_tx #(.CLKS_PER_BIT(8)) u_tx (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .tx   (tx),
        .busy (busy)
    );

    assign uo_out  = {6'b0, busy, tx};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
endmodule

// File: rtl/uart_byte_tx_baud_tick.sv
// Bit-period timer: pulses tick on the last cycle of every serial bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count 0..CLKS_PER_BIT-1; acceptance restarts the period so the start bit is full length.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) cnt_d = '0;
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter: one byte per handshake, LSB first, registered line.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_byte_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_byte_tx: CLKS_PER_BIT must be in 2..65535");
    end

    tx_state_t            state_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [2:0]           bit_idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 tick;
    logic                 accept;

    assign bus.ready = (state_q == IDLE) && !rst;
    assign accept    = bus.valid && bus.ready;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .tick  (tick)
    );

    // Frame sequencer; tx/busy are set together with the state so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= START;
                        shreg_q   <= bus.data_in;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        tx_q    <= shreg_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            // Next bit is shreg[1] now, shreg[0] after the shift.
                            shreg_q   <= {1'b0, shreg_q[DATA_BITS-1:1]};
                            tx_q      <= shreg_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx at CLKS_PER_BIT=4 and 2.
module tb_uart_byte_tx;
    localparam int CPB_A = 4;
    localparam int CPB_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic tx_a, busy_a, tx_b, busy_b;

    uart_byte_tx_if bus_a ();
    uart_byte_tx_if bus_b ();

    uart_byte_tx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a.slave), .tx(tx_a), .busy(busy_a));
    uart_byte_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b.slave), .tx(tx_b), .busy(busy_b));

    int   n_chk = 0;
    int   n_pass = 0;
    bit   armed = 1'b0;
    int   cyc = 0;
    logic qa[$];
    logic qb[$];
    int   acc_a = 0, acc_b = 0;
    int   last_acc_a = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle model for DUT A: queue holds the expected tx level of every busy cycle.
    always @(negedge clk) if (armed) begin
        bit er;
        er = !rst_a && (qa.size() == 0);
        chk("a_ready", bus_a.ready, er);
        chk("a_busy", busy_a, qa.size() != 0);
        chk("a_tx", tx_a, (qa.size() != 0) ? qa[0] : 1'b1);
        if (qa.size() != 0) void'(qa.pop_front());
        if (rst_a) qa.delete();
        else if (er && bus_a.valid) begin
            for (int b = 0; b < 10; b++) begin
                bit v;
                v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bus_a.data_in[b-1];
                repeat (CPB_A) qa.push_back(v);
            end
            acc_a++;
            last_acc_a = cyc;
        end
    end

    // Same model for DUT B.
    always @(negedge clk) if (armed) begin
        bit er;
        er = !rst_b && (qb.size() == 0);
        chk("b_ready", bus_b.ready, er);
        chk("b_busy", busy_b, qb.size() != 0);
        chk("b_tx", tx_b, (qb.size() != 0) ? qb[0] : 1'b1);
        if (qb.size() != 0) void'(qb.pop_front());
        if (rst_b) qb.delete();
        else if (er && bus_b.valid) begin
            for (int b = 0; b < 10; b++) begin
                bit v;
                v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bus_b.data_in[b-1];
                repeat (CPB_B) qb.push_back(v);
            end
            acc_b++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle_a(input int lim);
        int n = 0;
        while (qa.size() != 0 && n < lim) begin step(); n++; end
        chk("a_idle_wait", qa.size(), 0);
    endtask

    task automatic wait_idle_b(input int lim);
        int n = 0;
        while (qb.size() != 0 && n < lim) begin step(); n++; end
        chk("b_idle_wait", qb.size(), 0);
    endtask

    task automatic wait_acc_a(input int a0, input int lim);
        int n = 0;
        while (acc_a == a0 && n < lim) begin step(); n++; end
        chk("a_acc_wait", acc_a, a0 + 1);
    endtask

    task automatic send_a(input logic [7:0] d);
        wait_idle_a(500);
        bus_a.data_in = d;
        bus_a.valid   = 1'b1;
        step();
        bus_a.valid   = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        wait_idle_b(500);
        bus_b.data_in = d;
        bus_b.valid   = 1'b1;
        step();
        bus_b.valid   = 1'b0;
    endtask

    initial begin
        int a0, t1;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.valid = 1'b0; bus_a.data_in = 8'h00;
        bus_b.valid = 1'b0; bus_b.data_in = 8'h00;
        repeat (3) @(posedge clk);
        #2 armed = 1'b1;
        step();
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // Single byte.
        send_a(8'hA5);
        wait_idle_a(100);
        repeat (3) step();

        // Back-to-back with valid held high.
        a0 = acc_a;
        bus_a.data_in = 8'h00;
        bus_a.valid   = 1'b1;
        wait_acc_a(a0, 20);
        t1 = last_acc_a;
        bus_a.data_in = 8'hFF;
        wait_acc_a(a0 + 1, 100);
        bus_a.valid = 1'b0;
        chk("a_b2b_period", last_acc_a - t1, 10 * CPB_A + 1);
        wait_idle_a(100);
        repeat (3) step();

        // Ignored valid while busy, and data_in changing mid-frame.
        a0 = acc_a;
        send_a(8'hC3);
        repeat (10) step();
        bus_a.data_in = 8'h3C;
        bus_a.valid   = 1'b1;
        step();
        bus_a.valid   = 1'b0;
        repeat (5) step();
        bus_a.data_in = 8'h00;
        wait_idle_a(100);
        repeat (20) step();
        chk("a_ignored", acc_a, a0 + 1);

        // Reset during data bit 3, with valid offered in the reset cycle.
        send_a(8'h6B);
        repeat (17) step();
        chk("a_mid_busy", busy_a, 1'b1);
        rst_a = 1'b1;
        bus_a.data_in = 8'hEE;
        bus_a.valid   = 1'b1;
        step();
        rst_a = 1'b0;
        bus_a.valid = 1'b0;
        chk("a_rst_tx", tx_a, 1'b1);
        chk("a_rst_busy", busy_a, 1'b0);
        repeat (3) step();
        send_a(8'h81);
        wait_idle_a(100);

        // Minimum bit length.
        send_b(8'h55);
        wait_idle_b(100);

        repeat (5) step();
        chk("a_acc_total", acc_a, 6);
        chk("b_acc_total", acc_b, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Transmit-side serial block for the Tiny Tapeout user project. It serialises one 8-bit byte per handshake into an 8N1 UART frame on a single pin: one start bit, eight data bits LSB first, one stop bit. It drives the serial line out of the chip; the current project's bidirectional pins are inputs only. In the top level it sits between the parallel result (`ui_in + uio_in`) and `uo_out[0]`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 8: clock cycles per serial bit.
  - Legal range 2..65535.
  - Values outside the range are a compile-time error.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  8  byte to send; sampled only on acceptance.
- `valid`  in  1  a byte is offered on `data_in`.
- `ready`  out  1  the block can accept a byte this cycle.
- `tx`  out  1  serial line; idles high; registered.
- `busy`  out  1  a frame is in progress; registered.

## Operation
- **Acceptance:** a byte is accepted on any cycle where `valid && ready` at the rising edge.
  - `data_in` is latched into the shift register at acceptance.
  - Later changes to `data_in` have no effect on the frame.
- **`ready`:** combinational, equal to `(state == IDLE) && !rst`.
  - `valid` while `ready` is low is ignored. Nothing is queued.
- **State machine:** states are IDLE, START, DATA, STOP.
  - IDLE → START on acceptance.
  - START → DATA when the bit counter expires.
  - DATA → DATA while fewer than 8 bits have been sent.
  - DATA → STOP after bit 7.
  - STOP → IDLE when the bit counter expires.
- **`tx` per state:**
  - IDLE: 1.
  - START: 0.
  - DATA: `shreg[0]`, shifting right once per bit.
  - STOP: 1.
- **`busy`:** 1 in START, DATA and STOP; 0 in IDLE.
- **Counters:**
  - The cycle counter has width `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - The bit index is 3 bits and counts 0..7.
  - No other arithmetic.
- **Reset:**
  - Reset in any state forces IDLE, `tx=1`, `busy=0`, and clears both counters.
  - A partial frame is abandoned. The line returns high on the cycle after the reset edge.
  - There is no resume.

## Timing
- **Output reset values:** `tx=1`, `busy=0`. `ready` is 0 while `rst` is high and 1 on the first cycle after `rst` deasserts.
- **Latency:** acceptance at edge N gives `tx=0` and `busy=1` from edge N. The start bit is visible in the cycle after N.
- **Bit length:** each bit holds for exactly `CLKS_PER_BIT` cycles.
- **Frame length:** exactly `10*CLKS_PER_BIT` cycles. `ready` stays low for that whole window.
- **Back-to-back:**
  - `ready` returns high in the cycle after the last stop-bit cycle.
  - If `valid` is held high, the next start bit follows directly. The minimum gap between frames is one idle-high cycle.
  - Sustained rate is one byte per `10*CLKS_PER_BIT + 1` cycles.
- **`valid` and `rst` in the same cycle:** reset wins and nothing is accepted.

## Structure
- **Package `uart_pkg`:**
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`.
  - Constants `DATA_BITS = 8` and `STOP_BITS = 1`.
- **Sub-module `baud_tick`:**
  - Parameterised by `CLKS_PER_BIT`.
  - Inputs: `clk`, `rst`, and `clear`, asserted on acceptance.
  - Output: a one-cycle `tick` pulse at each bit boundary.
- **Top-level wrapper (`tt_um_*`):**
  - `rst = !rst_n`, synchronised there.
  - `data_in = ui_in + uio_in`, `valid = 1`, and `uo_out = {6'b0, busy, tx}`.
  - `uio_out = 0` and `uio_oe = 0`.

## Test plan
Scenarios 1–4 use `CLKS_PER_BIT=4`.
1. **Single byte:** send 0xA5. `tx` must read 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `busy` is high for 40 cycles, then `ready` returns high.
2. **Back-to-back:** hold `valid` with 0x00, then 0xFF. Frames must be separated by exactly 1 idle-high cycle, with 81 cycles from the first acceptance to the second frame's end.
3. **Ignored and late inputs:**
   - Pulse `valid` with 0x3C while `busy`. It is not accepted and no second frame is sent.
   - Change `data_in` mid-frame. The serial bits must still match the latched byte.
4. **Reset mid-frame:**
   - Assert `rst` during data bit 3. Next cycle: `tx=1`, `busy=0`.
   - After deassertion, send 0x81. The frame must be clean: 0,1,0,0,0,0,0,0,1,1.
5. **Boundary parameters:**
   - `CLKS_PER_BIT=2`, send 0x55: the 20-cycle frame must match exactly.
   - `CLKS_PER_BIT=1`: elaboration must fail.
